text_char_fetch: RTL and testbench

- Text-mode fetch stage directly upstream of the pixel shifter.
- Tracks the beam in character cells from the sync block's display enable and a frame-start pulse.
- Reads the character code from the text buffer RAM, then forms the glyph address for the char ROM.
- Delays display enable so the shifter sees each ROM byte stable for exactly 8 pixel clocks, aligned to the cell's first pixel.

---
 rtl/text_char_fetch.sv | 140 ++++++++++++++
 tb/tb_text_char_fetch.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/text_char_fetch.sv
// text_char_fetch: text-mode fetch stage ahead of the pixel shifter.
// Tracks the beam in character cells and reads the char code from the
// text buffer, then forms the glyph address for the char ROM.
// Ports:
//   vga_clk       pixel clock (rising edge)
//   reset_n       synchronous active-low reset
//   de_in         raw display enable from the sync generator
//   frame_start   one-cycle pulse in vertical blank
//   text_addr     text buffer read address (registered)
//   text_data     char code, valid one cycle after text_addr
//   char_rom_addr {char_code, glyph_row} to the char ROM (registered)
//   de_out        de_in delayed 4 cycles, gated by blanking
module text_char_fetch #(
    parameter int COLS    = 80,
    parameter int ROWS    = 30,
    parameter int GLYPH_H = 16,
    parameter int TADDR_W = 12
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic               de_in,
    input  logic               frame_start,
    output logic [TADDR_W-1:0] text_addr,
    input  logic [7:0]         text_data,
    output logic [11:0]        char_rom_addr,
    output logic               de_out
);

    localparam int PX_W   = 12;
    localparam int COL_W  = PX_W - 3;
    localparam int CROW_W = 8;

    localparam logic [COL_W-1:0]   COLS_C  = COL_W'(COLS);
    localparam logic [CROW_W-1:0]  ROWS_C  = CROW_W'(ROWS);
    localparam logic [CROW_W-1:0]  RLAST_C = CROW_W'(ROWS - 1);
    localparam logic [TADDR_W-1:0] COLS_T  = TADDR_W'(COLS);
    localparam logic [3:0]         GLAST_C = 4'(GLYPH_H - 1);

    logic [PX_W-1:0]    px_q, px_d;
    logic [3:0]         glyph_q, glyph_d;
    logic [CROW_W-1:0]  crow_q, crow_d;
    logic [TADDR_W-1:0] base_q, base_d;
    logic [TADDR_W-1:0] ta_q, ta_d;
    logic [11:0]        cra_q, cra_d;
    logic               de_prev_q;
    logic               v1_q, v2_q;
    logic [3:0]         g1_q, g2_q;
    logic [3:0]         de_sr_q, de_sr_d;

    logic [COL_W-1:0]   col;
    logic               blank;
    logic               fire;
    logic               fall;

    always_comb begin
        col   = px_q[PX_W-1:3];
        blank = (col >= COLS_C) || (crow_q >= ROWS_C);
        fire  = de_in & ~blank;
        fall  = de_prev_q & ~de_in;

        // px saturates so an absurdly long line cannot wrap into view
        px_d = '0;
        if (de_in) begin
            px_d = px_q;
            if (px_q != '1) begin
                px_d = px_q + 1'b1;
            end
        end

        glyph_d = glyph_q;
        crow_d  = crow_q;
        base_d  = base_q;
        if (frame_start) begin
            glyph_d = '0;
            crow_d  = '0;
            base_d  = '0;
        end else if (fall) begin
            if (glyph_q == GLAST_C) begin
                glyph_d = '0;
                if (crow_q != '1) begin
                    crow_d = crow_q + 1'b1;
                end
                // base stops at the last visible row
                if (crow_q < RLAST_C) begin
                    base_d = base_q + COLS_T;
                end
            end else begin
                glyph_d = glyph_q + 1'b1;
            end
        end

        ta_d = ta_q;
        if (fire) begin
            ta_d = base_q + TADDR_W'(col);
        end

        // only cells that were actually fetched update the ROM address
        cra_d = cra_q;
        if (v2_q) begin
            cra_d = {text_data, g2_q};
        end

        de_sr_d = {de_sr_q[2:0], fire};
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            px_q      <= '0;
            glyph_q   <= '0;
            crow_q    <= '0;
            base_q    <= '0;
            ta_q      <= '0;
            cra_q     <= '0;
            de_prev_q <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            g1_q      <= '0;
            g2_q      <= '0;
            de_sr_q   <= '0;
        end else begin
            px_q      <= px_d;
            glyph_q   <= glyph_d;
            crow_q    <= crow_d;
            base_q    <= base_d;
            ta_q      <= ta_d;
            cra_q     <= cra_d;
            de_prev_q <= de_in;
            v1_q      <= fire;
            v2_q      <= v1_q;
            g1_q      <= glyph_q;
            g2_q      <= g1_q;
            de_sr_q   <= de_sr_d;
        end
    end

    assign text_addr     = ta_q;
    assign char_rom_addr = cra_q;
    assign de_out        = de_sr_q[3];

endmodule

// File: tb/tb_text_char_fetch.sv
// tb_text_char_fetch: directed bench for text_char_fetch.
// RAM model returns text_addr[7:0] one cycle after the address.
module tb_text_char_fetch;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        de_in = 1'b0;
    logic        frame_start = 1'b0;
    logic [11:0] text_addr;
    logic [7:0]  text_data;
    logic [11:0] char_rom_addr;
    logic        de_out;

    int nvec = 0;
    int nerr = 0;
    int exp_ta = 0;
    int exp_cra = 0;

    text_char_fetch #(
        .COLS(80), .ROWS(30), .GLYPH_H(16), .TADDR_W(12)
    ) dut (
        .vga_clk(vga_clk),
        .reset_n(reset_n),
        .de_in(de_in),
        .frame_start(frame_start),
        .text_addr(text_addr),
        .text_data(text_data),
        .char_rom_addr(char_rom_addr),
        .de_out(de_out)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) text_data <= text_addr[7:0];

    task automatic step;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cmin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One line of len display cycles plus a 6-cycle gap; expected values
    // are computed from the cell position and the row/glyph of the line.
    task automatic run_line(input int len, input int base, input int glyph,
                            input bit vis, input bit fs_fall);
        int exp_de;
        for (int t = 0; t <= len + 5; t++) begin
            de_in = (t < len);
            frame_start = fs_fall && (t == len);
            if (vis && t >= 1 && t - 1 < len)
                exp_ta = base + cmin((t - 1) / 8, 79);
            if (vis && t >= 3 && t - 3 < len)
                exp_cra = (((base + cmin((t - 3) / 8, 79)) & 255) << 4) | glyph;
            exp_de = (vis && t >= 4 && t - 4 < len && (t - 4) / 8 < 80) ? 1 : 0;
            chk("text_addr", 32'(text_addr), 32'(exp_ta));
            chk("char_rom_addr", 32'(char_rom_addr), 32'(exp_cra));
            chk("de_out", 32'(de_out), 32'(exp_de));
            step();
        end
        frame_start = 1'b0;
    endtask

    task automatic pulse_fs;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
    endtask

    initial begin
        // reset held with de_in toggling
        for (int i = 0; i < 3; i++) begin
            de_in = i[0];
            step();
            chk("rst_text_addr", 32'(text_addr), 32'd0);
            chk("rst_char_rom_addr", 32'(char_rom_addr), 32'd0);
            chk("rst_de_out", 32'(de_out), 32'd0);
        end
        reset_n = 1'b1;
        de_in = 1'b0;
        step();
        step();
        exp_ta = 0;
        exp_cra = 0;

        pulse_fs();
        run_line(640, 0, 0, 1'b1, 1'b0);
        for (int ln = 1; ln < 16; ln++)
            run_line(16, 0, ln, 1'b1, 1'b0);
        run_line(80, 80, 0, 1'b1, 1'b0);
        // over-wide line saturates at row_base+79
        run_line(700, 80, 1, 1'b1, 1'b0);
        for (int ln = 18; ln < 480; ln++)
            run_line(8, (ln / 16) * 80, ln % 16, 1'b1, 1'b0);
        // rows past the last one stay blank
        for (int ln = 480; ln < 496; ln++)
            run_line(16, 0, 0, 1'b0, 1'b0);
        chk("ta_max", 32'(text_addr <= 12'd2399), 32'd1);

        pulse_fs();
        for (int ln = 0; ln < 17; ln++)
            run_line(16, (ln / 16) * 80, ln % 16, 1'b1, 1'b0);
        // frame_start coincident with the falling edge wins
        run_line(16, 80, 1, 1'b1, 1'b1);
        run_line(16, 0, 0, 1'b1, 1'b0);

        // reset in the middle of a line at px=100
        for (int t = 0; t < 100; t++) begin
            de_in = 1'b1;
            step();
        end
        reset_n = 1'b0;
        step();
        chk("mid_rst_de_out", 32'(de_out), 32'd0);
        chk("mid_rst_text_addr", 32'(text_addr), 32'd0);
        chk("mid_rst_char_rom_addr", 32'(char_rom_addr), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            de_in = 1'b1;
            chk("post_rst_de_out", 32'(de_out), (i >= 4) ? 32'd1 : 32'd0);
            if (i >= 1)
                chk("post_rst_text_addr", 32'(text_addr), 32'd0);
            step();
        end
        de_in = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
